// File: rtl/lcd_write_engine_if.sv
// Command handshake between the I/O LSU and the LCD write engine: one byte per vld/rdy transfer.
interface lcd_write_engine_if;
    logic       cmd_vld;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       cmd_rdy;

    modport master (output cmd_vld, output cmd_rs, output cmd_data, input cmd_rdy);
    modport slave  (input cmd_vld, input cmd_rs, input cmd_data, output cmd_rdy);
endinterface

// File: rtl/lcd_write_engine.sv
// HD44780 8-bit write engine: setup, EN pulse, hold, busy-wait per accepted byte (LCD_INIT_EN adds power-up init).
// Latency: SETUP+PULSE+HOLD+wait clocks from handshake to next cmd_rdy (wait = LONG for clear/home, else EXEC).
// Backpressure: cmd_rdy is registered and high only in IDLE; bytes offered while busy are held off, not dropped.
module lcd_write_engine #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 25,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 4000,
    parameter int LONG_CYC  = 160000,
    parameter int INIT_CYC  = 1500000
) (
    input  logic                clk,
    input  logic                rst,
    lcd_write_engine_if.slave   cmd,
    output logic                busy,
    output logic [7:0]          lcd_data,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic                lcd_en,
    output logic                lcd_on
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                  max2(LONG_CYC, INIT_CYC));
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
`ifdef LCD_INIT_EN
    localparam logic [2:0] ST_PWRUP = 3'd5;
`endif

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wait_load;
    logic          cnt_zero;
    logic          rdy_q;

`ifdef LCD_INIT_EN
    logic [2:0]    init_idx;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    // Clear (0x01) and home (0x02/0x03) need the long busy wait; everything else is a normal exec.
    always_comb begin
        wait_load = CW'(EXEC_CYC - 1);
        if (!lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02 || lcd_data == 8'h03))
            wait_load = CW'(LONG_CYC - 1);
    end

    assign cnt_zero    = (cnt == '0);
    assign cmd.cmd_rdy = rdy_q;
    assign busy        = ~rdy_q;
    assign lcd_rw      = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef LCD_INIT_EN
            state    <= ST_PWRUP;
            cnt      <= CW'(INIT_CYC - 1);
            init_idx <= 3'd0;
`else
            state    <= ST_IDLE;
            cnt      <= '0;
`endif
            rdy_q    <= 1'b0;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_on   <= 1'b0;
        end else begin
            lcd_on <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (rdy_q && cmd.cmd_vld) begin
                        lcd_rs   <= cmd.cmd_rs;
                        lcd_data <= cmd.cmd_data;
                        cnt      <= CW'(SETUP_CYC - 1);
                        state    <= ST_SETUP;
                        rdy_q    <= 1'b0;
                    end else begin
                        rdy_q    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        lcd_en <= 1'b1;
                        cnt    <= CW'(PULSE_CYC - 1);
                        state  <= ST_PULSE;
                    end else begin
                        cnt    <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_zero) begin
                        lcd_en <= 1'b0;
                        cnt    <= CW'(HOLD_CYC - 1);
                        state  <= ST_HOLD;
                    end else begin
                        cnt    <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        cnt   <= wait_load;
                        state <= ST_WAIT;
                    end else begin
                        cnt   <= cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_zero) begin
`ifdef LCD_INIT_EN
                        if (init_idx < 3'd4) begin
                            lcd_rs   <= 1'b0;
                            lcd_data <= init_byte(init_idx[1:0]);
                            init_idx <= init_idx + 3'd1;
                            cnt      <= CW'(SETUP_CYC - 1);
                            state    <= ST_SETUP;
                        end else begin
                            state    <= ST_IDLE;
                            rdy_q    <= 1'b1;
                        end
`else
                        state <= ST_IDLE;
                        rdy_q <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef LCD_INIT_EN
                ST_PWRUP: begin
                    if (cnt_zero) begin
                        lcd_rs   <= 1'b0;
                        lcd_data <= init_byte(2'd0);
                        init_idx <= 3'd1;
                        cnt      <= CW'(SETUP_CYC - 1);
                        state    <= ST_SETUP;
                    end else begin
                        cnt      <= cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    lcd_en <= 1'b0;
                    rdy_q  <= 1'b0;
                    cnt    <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Scoreboard bench for lcd_write_engine: randomized bytes, expected EN pulses and busy times from a timing model.
module tb_lcd_write_engine;

    localparam int S = 2;
    localparam int P = 3;
    localparam int H = 2;
    localparam int E = 5;
    localparam int L = 20;
    localparam int I = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on;

    lcd_write_engine_if ifc ();

    lcd_write_engine #(
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
        .EXEC_CYC(E), .LONG_CYC(L), .INIT_CYC(I)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (ifc),
        .busy     (busy),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_on   (lcd_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         hs_edge;   // posedge count of acceptance, -1 for autonomous init bytes
        int         lat;       // expected clocks from acceptance to rdy
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference timing: every byte costs the three bus phases plus a busy wait chosen by command class.
    function automatic int model_lat(input logic rs, input logic [7:0] d);
        int w;
        w = (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? L : E;
        return S + P + H + w;
    endfunction

    task automatic push_init();
`ifdef LCD_INIT_EN
        logic [7:0] seq [4];
        seq = '{8'h38, 8'h0C, 8'h01, 8'h06};
        for (int k = 0; k < 4; k++)
            sb.push_back('{rs: 1'b0, data: seq[k], hs_edge: -1, lat: 0});
`endif
    endtask

    // Called at a negedge; returns at a negedge after the byte has been accepted.
    task automatic send(input logic rs, input logic [7:0] d, input int gap);
        int n;
        ifc.cmd_vld  = 1'b1;
        ifc.cmd_rs   = rs;
        ifc.cmd_data = d;
        n = 0;
        while (!ifc.cmd_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.cmd_rdy) begin
            chk("accept_timeout_rdy", int'(ifc.cmd_rdy), 1);
        end else begin
            sb.push_back('{rs: rs, data: d, hs_edge: cyc + 1, lat: model_lat(rs, d)});
            @(negedge clk);
        end
        for (int g = 0; g < gap; g++) begin
            ifc.cmd_vld  = 1'b0;
            ifc.cmd_data = 8'($urandom);
            ifc.cmd_rs   = 1'($urandom);
            @(negedge clk);
        end
    endtask

    // Monitor: EN edges pop the scoreboard; rdy return closes the transfer timing check.
    logic prev_en  = 1'b0;
    logic prev_rdy = 1'b0;
    bit   in_pulse = 1'b0;
    bit   cur_vld  = 1'b0;
    int   width    = 0;
    exp_t cur;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pulse = 1'b0;
                cur_vld  = 1'b0;
            end else begin
                if (lcd_en && !prev_en) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_en_pulse: data %0h rs %0b with empty scoreboard", lcd_data, lcd_rs);
                    end else begin
                        cur = sb.pop_front();
                        cur_vld = 1'b1;
                        chk("en_rs", int'(lcd_rs), int'(cur.rs));
                        chk("en_data", int'(lcd_data), int'(cur.data));
                        if (cur.hs_edge >= 0)
                            chk("setup_clocks", cyc - cur.hs_edge, S);
                    end
                    in_pulse = 1'b1;
                    width = 0;
                end
                if (lcd_en)
                    width++;
                if (!lcd_en && prev_en && in_pulse) begin
                    chk("en_width", width, P);
                    in_pulse = 1'b0;
                end
                if (ifc.cmd_rdy && !prev_rdy && cur_vld) begin
                    if (cur.hs_edge >= 0)
                        chk("rdy_latency", cyc - cur.hs_edge, cur.lat);
                    chk("data_hold", int'(lcd_data), int'(cur.data));
                    cur_vld = 1'b0;
                end
            end
            prev_en  = lcd_en;
            prev_rdy = ifc.cmd_rdy;
        end
    end

    initial begin
        logic       rs;
        logic [7:0] d;
        int         n;

        rst          = 1'b1;
        ifc.cmd_vld  = 1'b0;
        ifc.cmd_rs   = 1'b0;
        ifc.cmd_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_en", int'(lcd_en), 0);
        chk("rst_data", int'(lcd_data), 0);
        chk("rst_rs", int'(lcd_rs), 0);
        chk("rst_rw", int'(lcd_rw), 0);
        chk("rst_on", int'(lcd_on), 0);
        chk("rst_rdy", int'(ifc.cmd_rdy), 0);
        chk("rst_busy", int'(busy), 1);

        rst = 1'b0;
        push_init();
        @(negedge clk);
`ifdef LCD_INIT_EN
        chk("post_rst_rdy", int'(ifc.cmd_rdy), 0);
`else
        chk("post_rst_rdy", int'(ifc.cmd_rdy), 1);
`endif
        chk("post_rst_on", int'(lcd_on), 1);

        // Directed: data write, clear, data 0x01, then a back-to-back burst.
        send(1'b1, 8'h41, 2);
        send(1'b0, 8'h01, 1);
        send(1'b1, 8'h01, 0);
        send(1'b1, 8'h48, 0);
        send(1'b1, 8'h49, 0);
        send(1'b1, 8'h21, 3);
        send(1'b0, 8'h02, 0);
        send(1'b0, 8'h03, 2);

        // Reset in the middle of the EN pulse.
        send(1'b1, 8'h55, 0);
        ifc.cmd_vld = 1'b0;
        n = 0;
        while (!lcd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pre_abort_en", int'(lcd_en), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_en", int'(lcd_en), 0);
        chk("abort_data", int'(lcd_data), 0);
        chk("abort_rs", int'(lcd_rs), 0);
        chk("abort_rdy", int'(ifc.cmd_rdy), 0);
        rst = 1'b0;
        push_init();
        @(negedge clk);
`ifndef LCD_INIT_EN
        chk("abort_release_rdy", int'(ifc.cmd_rdy), 1);
`endif
        send(1'b1, 8'h5A, 1);

        // Randomized traffic with a bias toward the long-wait opcodes.
        for (int k = 0; k < 40; k++) begin
            rs = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            send(rs, d, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
        end
        ifc.cmd_vld = 1'b0;

        n = 0;
        while ((sb.size() != 0 || !ifc.cmd_rdy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", sb.size(), 0);
        chk("drain_rdy", int'(ifc.cmd_rdy), 1);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
